// File: rtl/microsequencer_ctrl.sv
// microsequencer_ctrl
//   Microprogrammed control unit: writable microstore, 8-mode next-address
//   selector with condition test/inversion, microsubroutine stack and the
//   pipelined control register that drives the datapath Moore lines.
//
// Ports
//   Clk      : clock, all state updates on posedge
//   Reset    : synchronous, active-high reset
//   Hold     : stall, freezes sequencing (CrOut, State, stack, StackErr)
//   Encoder  : instruction-decode entry address (mode 000)
//   Cond     : condition lines, selected by the microword S field
//   WrEn     : microstore write enable (ignored while Reset is high)
//   WrAddr   : microstore write address
//   WrData   : microstore write data
//   CrOut    : control register, the current microinstruction
//   Moore    : middle field of CrOut, the datapath Moore control lines
//   State    : microaddress of the word held in CrOut
//   Valid    : CrOut holds a fetched microinstruction (sequencer FSM state)
//   StackErr : sticky stack overflow/underflow flag, cleared by Reset
//
// Flow control: Hold is a plain stall with no ready side. While Valid=1 and
// Hold=1 nothing in the sequencer moves; the first cycle after Reset always
// fetches Mem[0] regardless of Hold.
//
// Microword layout, MSB first: N[2:0] | INV | S[SEL_W-1:0] | Moore | CRF.

module microsequencer_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int WORD_W  = 32,
  parameter int SEL_W   = 2,
  parameter int STACK_D = 4
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Hold,
  input  logic [ADDR_W-1:0]                Encoder,
  input  logic [2**SEL_W-1:0]              Cond,
  input  logic                             WrEn,
  input  logic [ADDR_W-1:0]                WrAddr,
  input  logic [WORD_W-1:0]                WrData,
  output logic [WORD_W-1:0]                CrOut,
  output logic [WORD_W-4-SEL_W-ADDR_W-1:0] Moore,
  output logic [ADDR_W-1:0]                State,
  output logic                             Valid,
  output logic                             StackErr
);

  localparam int MOORE_W = WORD_W - 4 - SEL_W - ADDR_W;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int SP_W    = $clog2(STACK_D + 1);
  localparam int IDX_W   = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  // Sequencer FSM: BOOT is the one cycle after Reset that loads Mem[0].
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  seq_state_t              r_seq;
  seq_state_t              w_seq_next;

  logic [WORD_W-1:0]       r_mem [DEPTH];
  logic [WORD_W-1:0]       r_cr;
  logic [ADDR_W-1:0]       r_state;
  logic [ADDR_W-1:0]       r_stack [STACK_D];
  logic [SP_W-1:0]         r_sp;
  logic                    r_err;

  logic [2:0]              w_n;
  logic                    w_inv;
  logic [SEL_W-1:0]        w_sel;
  logic [ADDR_W-1:0]       w_crf;
  logic                    w_t;
  logic [ADDR_W-1:0]       w_inc;
  logic [IDX_W-1:0]        w_push_idx;
  logic [IDX_W-1:0]        w_top_idx;
  logic                    w_stack_full;
  logic                    w_stack_empty;
  logic [ADDR_W-1:0]       w_na;
  logic                    w_push;
  logic                    w_pop;

  // Field decode of the current microword
  assign w_n    = r_cr[WORD_W-1 -: 3];
  assign w_inv  = r_cr[WORD_W-4];
  assign w_sel  = r_cr[WORD_W-5 -: SEL_W];
  assign w_crf  = r_cr[ADDR_W-1:0];
  assign w_t    = Cond[w_sel] ^ w_inv;
  assign w_inc  = r_state + ADDR_W'(1);   // wraps modulo 2**ADDR_W

  assign w_push_idx    = IDX_W'(r_sp);
  assign w_top_idx     = IDX_W'(r_sp - SP_W'(1));
  assign w_stack_full  = (r_sp == SP_W'(STACK_D));
  assign w_stack_empty = (r_sp == '0);

  // Next-address selection
  always_comb begin
    w_na   = w_inc;
    w_push = 1'b0;
    w_pop  = 1'b0;
    case (w_n)
      3'b000: w_na = Encoder;
      3'b001: w_na = '0;
      3'b010: w_na = w_crf;
      3'b011: w_na = w_inc;
      3'b100: w_na = w_t ? w_crf : w_inc;
      3'b101: begin
        w_na   = w_crf;
        w_push = 1'b1;
      end
      3'b110: begin
        // Underflow falls back to the fetch address
        w_na  = w_stack_empty ? '0 : r_stack[w_top_idx];
        w_pop = 1'b1;
      end
      3'b111: w_na = w_t ? w_inc : r_state;
      default: w_na = w_inc;
    endcase
  end

  // FSM next state
  always_comb begin
    w_seq_next = r_seq;
    case (r_seq)
      ST_BOOT: w_seq_next = ST_RUN;
      ST_RUN:  w_seq_next = ST_RUN;
      default: w_seq_next = ST_BOOT;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) r_seq <= ST_BOOT;
    else       r_seq <= w_seq_next;
  end

  // Control register, microaddress and stack
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cr    <= '0;
      r_state <= '0;
      r_sp    <= '0;
      r_err   <= 1'b0;
    end else if (r_seq == ST_BOOT) begin
      r_cr    <= r_mem[0];
      r_state <= '0;
    end else if (!Hold) begin
      r_cr    <= r_mem[w_na];   // same-cycle write to w_na is not seen here
      r_state <= w_na;
      if (w_push) begin
        if (w_stack_full) begin
          r_err <= 1'b1;        // jump taken, return address dropped
        end else begin
          r_stack[w_push_idx] <= w_inc;
          r_sp                <= r_sp + SP_W'(1);
        end
      end
      if (w_pop) begin
        if (w_stack_empty) r_err <= 1'b1;
        else               r_sp  <= r_sp - SP_W'(1);
      end
    end
  end

  // Microstore write port, independent of Hold and Valid
  always_ff @(posedge Clk) begin
    if (WrEn && !Reset) r_mem[WrAddr] <= WrData;
  end

  assign CrOut    = r_cr;
  assign Moore    = r_cr[ADDR_W +: MOORE_W];
  assign State    = r_state;
  assign Valid    = (r_seq == ST_RUN);
  assign StackErr = r_err;

endmodule

// File: tb/tb_microsequencer_ctrl.sv
// tb_microsequencer_ctrl
//   Directed bench for microsequencer_ctrl with default parameters
//   (ADDR_W=6, WORD_W=32, SEL_W=2, STACK_D=4). Microwords are built with
//   mk(); a bench-side shadow of every word written gives expected CrOut.

module tb_microsequencer_ctrl;

  logic        Clk;
  logic        Reset;
  logic        Hold;
  logic [5:0]  Encoder;
  logic [3:0]  Cond;
  logic        WrEn;
  logic [5:0]  WrAddr;
  logic [31:0] WrData;
  logic [31:0] CrOut;
  logic [19:0] Moore;
  logic [5:0]  State;
  logic        Valid;
  logic        StackErr;

  int          total;
  int          bad;
  logic [31:0] sh [64];
  logic [31:0] old10;
  logic [31:0] new10;

  microsequencer_ctrl dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Hold     (Hold),
    .Encoder  (Encoder),
    .Cond     (Cond),
    .WrEn     (WrEn),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .CrOut    (CrOut),
    .Moore    (Moore),
    .State    (State),
    .Valid    (Valid),
    .StackErr (StackErr)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mk(input logic [2:0] n, input logic inv,
                                     input logic [1:0] s, input logic [19:0] m,
                                     input logic [5:0] crf);
    return {n, inv, s, m, crf};
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    WrEn   = 1'b1;
    WrAddr = a;
    WrData = d;
    sh[a]  = d;
    step();
    WrEn   = 1'b0;
  endtask

  // Reset for one edge, then the boot edge: afterwards State=0, Valid=1
  task automatic boot();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    Reset   = 1'b1;
    Hold    = 1'b0;
    Encoder = '0;
    Cond    = '0;
    WrEn    = 1'b0;
    WrAddr  = '0;
    WrData  = '0;
    step();
    Reset   = 1'b0;

    // ---------------- Reset and boot ----------------
    wr(6'd0, mk(3'b011, 1'b0, 2'd0, 20'hA5A5A, 6'd0));
    wr(6'd1, mk(3'b010, 1'b0, 2'd0, 20'h12345, 6'd5));
    wr(6'd5, mk(3'b001, 1'b0, 2'd0, 20'h0F0F0, 6'd0));
    Reset = 1'b1;
    step();
    step();
    chk("rst_cr",    CrOut, 32'h0);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_moore", 32'(Moore), 32'd0);
    chk("rst_err",   32'(StackErr), 32'd0);
    Reset = 1'b0;
    #2;
    chk("pre_boot_valid", 32'(Valid), 32'd0);
    step();
    chk("boot_valid", 32'(Valid), 32'd1);
    chk("boot_s0",    32'(State), 32'd0);
    chk("boot_cr0",   CrOut, sh[0]);
    chk("boot_moore", 32'(Moore), 32'hA5A5A);
    step();
    chk("boot_s1",  32'(State), 32'd1);
    chk("boot_cr1", CrOut, sh[1]);
    step();
    chk("boot_s5",  32'(State), 32'd5);
    chk("boot_cr5", CrOut, sh[5]);
    step();
    chk("boot_s0b", 32'(State), 32'd0);
    step();
    chk("boot_s1b", 32'(State), 32'd1);

    // ---------------- Conditional branch / inversion ----------------
    wr(6'd0, mk(3'b010, 1'b0, 2'd0, 20'h0, 6'd2));
    wr(6'd2, mk(3'b100, 1'b0, 2'd2, 20'h00022, 6'd9));
    wr(6'd9, mk(3'b111, 1'b0, 2'd0, 20'h0, 6'd0));
    wr(6'd3, mk(3'b111, 1'b0, 2'd0, 20'h0, 6'd0));
    Cond = 4'b0100;
    boot(); step(); step();
    chk("cond_true",  32'(State), 32'd9);
    Cond = 4'b0000;
    boot(); step(); step();
    chk("cond_false", 32'(State), 32'd3);
    wr(6'd2, mk(3'b100, 1'b1, 2'd2, 20'h00022, 6'd9));
    Cond = 4'b0100;
    boot(); step(); step();
    chk("inv_true",  32'(State), 32'd3);
    Cond = 4'b0000;
    boot(); step(); step();
    chk("inv_false", 32'(State), 32'd9);

    // ---------------- Subroutine call / return ----------------
    wr(6'd0,  mk(3'b010, 1'b0, 2'd0, 20'h0, 6'd3));
    wr(6'd3,  mk(3'b101, 1'b0, 2'd0, 20'h00033, 6'd20));
    wr(6'd20, mk(3'b110, 1'b0, 2'd0, 20'h0, 6'd0));
    wr(6'd4,  mk(3'b111, 1'b0, 2'd0, 20'h0, 6'd0));
    boot();
    step();
    chk("call_s3",  32'(State), 32'd3);
    step();
    chk("call_s20", 32'(State), 32'd20);
    step();
    chk("ret_s4",   32'(State), 32'd4);
    chk("ret_err",  32'(StackErr), 32'd0);

    // Five nested calls: the fifth overflows
    wr(6'd0, mk(3'b010, 1'b0, 2'd0, 20'h0, 6'd40));
    for (int i = 40; i < 45; i++) wr(6'(i), mk(3'b101, 1'b0, 2'd0, 20'h0, 6'(i + 1)));
    wr(6'd45, mk(3'b111, 1'b0, 2'd0, 20'h0, 6'd0));
    boot();
    for (int i = 0; i < 5; i++) step();
    chk("nest_s44",  32'(State), 32'd44);
    chk("nest_err0", 32'(StackErr), 32'd0);
    step();
    chk("ovf_s45",  32'(State), 32'd45);
    chk("ovf_err",  32'(StackErr), 32'd1);
    step();
    chk("ovf_err_sticky", 32'(StackErr), 32'd1);

    // Return on empty stack
    wr(6'd0,  mk(3'b010, 1'b0, 2'd0, 20'h0, 6'd50));
    wr(6'd50, mk(3'b110, 1'b0, 2'd0, 20'h0, 6'd0));
    boot();
    step();
    chk("unf_s50",  32'(State), 32'd50);
    chk("unf_err0", 32'(StackErr), 32'd0);
    step();
    chk("unf_s0",   32'(State), 32'd0);
    chk("unf_err",  32'(StackErr), 32'd1);
    step(); step();
    chk("unf_err_sticky", 32'(StackErr), 32'd1);
    Reset = 1'b1;
    step();
    chk("unf_err_clr", 32'(StackErr), 32'd0);
    Reset = 1'b0;

    // ---------------- Wait and hold ----------------
    wr(6'd0,  mk(3'b010, 1'b0, 2'd0, 20'h0, 6'd7));
    wr(6'd7,  mk(3'b111, 1'b0, 2'd0, 20'h00077, 6'd0));
    wr(6'd8,  mk(3'b011, 1'b0, 2'd0, 20'h00088, 6'd0));
    wr(6'd9,  mk(3'b011, 1'b0, 2'd0, 20'h00099, 6'd0));
    wr(6'd10, mk(3'b010, 1'b0, 2'd0, 20'hAAAAA, 6'd10));
    wr(6'd63, mk(3'b011, 1'b0, 2'd0, 20'h0003F, 6'd0));
    Cond = 4'b0000;
    boot();
    step();
    chk("wait_s7", 32'(State), 32'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_spin", 32'(State), 32'd7);
    end
    Cond = 4'b0001;
    step();
    chk("wait_go", 32'(State), 32'd8);
    Hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_state", 32'(State), 32'd8);
      chk("hold_cr",    CrOut, sh[8]);
    end
    Hold = 1'b0;
    step();
    chk("hold_resume", 32'(State), 32'd9);

    // ---------------- Write collision and wrap ----------------
    old10  = sh[10];
    new10  = mk(3'b010, 1'b0, 2'd0, 20'h55555, 6'd63);
    WrEn   = 1'b1;
    WrAddr = 6'd10;
    WrData = new10;
    step();
    WrEn   = 1'b0;
    sh[10] = new10;
    chk("coll_s10",    32'(State), 32'd10);
    chk("coll_old_cr", CrOut, old10);
    step();
    chk("coll_new_cr", CrOut, new10);
    step();
    chk("wrap_s63", 32'(State), 32'd63);
    step();
    chk("wrap_s0",  32'(State), 32'd0);

    // ---------------- Encoder dispatch and reset mid-run ----------------
    wr(6'd0,  mk(3'b000, 1'b0, 2'd0, 20'h000E0, 6'd0));
    wr(6'd33, mk(3'b111, 1'b0, 2'd0, 20'h00333, 6'd0));
    Cond    = 4'b0000;
    Encoder = 6'd33;
    Hold    = 1'b1;
    Reset   = 1'b1;
    step();
    Reset   = 1'b0;
    step();
    chk("boot_hold_valid", 32'(Valid), 32'd1);
    chk("boot_hold_cr",    CrOut, sh[0]);
    Hold = 1'b0;
    step();
    chk("enc_s33",  32'(State), 32'd33);
    chk("enc_cr33", CrOut, sh[33]);
    Reset = 1'b1;
    step();
    chk("midrst_cr",    CrOut, 32'h0);
    chk("midrst_state", 32'(State), 32'd0);
    chk("midrst_valid", 32'(Valid), 32'd0);
    chk("midrst_moore", 32'(Moore), 32'd0);
    Reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microsequencer_ctrl.md
Name: microsequencer_ctrl

Overview:
- Parametrised microprogrammed control unit for the ARM datapath controller. It replaces the separate microstore, next-address mux and control register with one sequenced block.
- Contains:
  - a writable microstore;
  - an 8-mode next-address selector with condition test and inversion;
  - a microsubroutine stack;
  - the pipelined control register that drives the datapath Moore lines.

Parameters:
- ADDR_W, 6, microaddress width; microstore depth is 2**ADDR_W.
- WORD_W, 32, microinstruction width.
- SEL_W, 2, condition-select width; condition inputs number 2**SEL_W.
- STACK_D, 4, microstack depth (entries).
- Constraint: WORD_W >= 4+SEL_W+ADDR_W.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Hold  in  1  stall; freezes sequencing.
- Encoder  in  ADDR_W  instruction-decode entry address.
- Cond  in  2**SEL_W  status/condition lines.
- WrEn  in  1  microstore write enable.
- WrAddr  in  ADDR_W  microstore write address.
- WrData  in  WORD_W  microstore write data.
- CrOut  out  WORD_W  control register (current microinstruction).
- Moore  out  WORD_W-4-SEL_W-ADDR_W  Moore control lines, equal to CrOut middle field.
- State  out  ADDR_W  address of the microinstruction held in CrOut.
- Valid  out  1  CrOut holds a fetched microinstruction.
- StackErr  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high. No asynchronous paths.
- Microword fields, MSB first:
  - N[2:0] = CrOut[WORD_W-1:WORD_W-3];
  - INV = CrOut[WORD_W-4];
  - S = next SEL_W bits;
  - Moore field;
  - CRF = CrOut[ADDR_W-1:0].
- Condition: T = Cond[S] ^ INV. Increment: Inc = State+1, wrapping modulo 2**ADDR_W (max address +1 -> 0).
- Next address NA, combinational from CrOut, State, Cond, stack top:
  - 000 Encoder;
  - 001 address 0 (fetch);
  - 010 CRF;
  - 011 Inc;
  - 100 T ? CRF : Inc;
  - 101 call: NA=CRF, push Inc;
  - 110 return: NA=stack top, pop;
  - 111 wait: T ? Inc : State.
- Per posedge, priority Reset > !Valid > Hold > normal:
  - Reset: CrOut=0, State=0, Valid=0, stack pointer=0, StackErr=0. Microstore contents are not cleared.
  - First clock after Reset deasserts, with Valid=0: CrOut<=Mem[0], State<=0, Valid<=1. Hold is ignored in this cycle.
  - Valid=1, Hold=1: CrOut, State, stack and StackErr unchanged.
  - Valid=1, Hold=0: CrOut<=Mem[NA], State<=NA, stack updated per mode.
- Latency: a microinstruction takes effect on Moore one cycle after its address is selected. Consecutive microinstructions issue one per clock.
- Microstore write:
  - When WrEn=1, Mem[WrAddr]<=WrData at posedge. Writes are independent of Hold and Valid; they are suppressed during Reset.
  - Read and write to the same address in the same cycle: CrOut receives the old content. The new content is visible from the next fetch.
- Stack:
  - Call with STACK_D entries already present (overflow): jump still taken, push discarded, StackErr<=1.
  - Return with the stack empty (underflow): NA=0, StackErr<=1.
  - StackErr is cleared only by Reset.
- Mode 111 with T false spins indefinitely. Reset mid-spin or mid-subroutine returns to the reset state above.
- Moore is a pure slice of CrOut, so it is 0 during reset.

Test Plan:
- Reset, then boot: load Mem[0]=011 word, Mem[1]=010 word with CRF=5, Mem[5]=001 word. Hold Reset 2 cycles, release -> Valid=0 until first edge, then State sequence 0,1,5,0,1. CrOut equals each Mem entry.
- Conditional/inversion: Mem[2]=100, S=2, INV=0, CRF=9:
  - Cond=4'b0100 -> next State=9;
  - Cond=0 -> State=3;
  - repeat with INV=1 -> outcomes swap.
- Subroutine: Mem[3]=101 CRF=20; Mem[20]=110 -> State 3,20,4. With 5 nested calls and STACK_D=4 -> 5th call jumps, StackErr=1. A return on the empty stack -> State=0, StackErr stays 1 until Reset.
- Wait and hold:
  - Mem[7]=111 S=0: Cond[0]=0 for 3 cycles -> State stays 7; Cond[0]=1 -> State=8.
  - Hold=1 for 2 cycles mid-sequence -> State, CrOut frozen; Hold=0 resumes.
- Write collision and wrap: WrEn to Mem[10] in the same cycle State becomes 10 -> CrOut=old Mem[10]; the next fetch of 10 returns new data. Mem[63]=011 -> next State=0.
- Encoder dispatch: Mem[0]=000 word, Encoder=6'd33 -> State=33. Reset asserted while State=33 -> next edge CrOut=0, State=0, Valid=0.
